// File: rtl/bitwise_selfcheck_if.sv
// Connection bundle between the self-check engine and the bitwise OR/NOT block under test.
// The master side is the engine; the slave side is the block plus whatever pulses start.
interface bitwise_selfcheck_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic [W-1:0]     a_out;
  logic [W-1:0]     b_out;
  logic [W-1:0]     or_bitwise_in;
  logic             or_logical_in;
  logic [2*W-1:0]   not_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_vld;
  logic [2*W-1:0]   first_fail_vec;

  modport master (
    input  start, or_bitwise_in, or_logical_in, not_in,
    output a_out, b_out, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );

  modport slave (
    output start, or_bitwise_in, or_logical_in, not_in,
    input  a_out, b_out, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );
endinterface

// File: rtl/bitwise_selfcheck.sv
// Exhaustive stimulus/response engine for the bitwise OR/NOT block: sweeps every {a,b},
// compares the three responses against locally computed values and records the results.
module bitwise_selfcheck #(
  parameter int unsigned W      = 3,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  bitwise_selfcheck_if.master bus
);
  localparam int unsigned VW = 2 * W;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    SettleLast = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [VW-1:0]    VecLast    = '1;
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [VW-1:0]    r_vec, w_vec_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic             r_ff_vld, w_ff_vld_d;
  logic [VW-1:0]    r_ff_vec, w_ff_vec_d;

  logic [W-1:0]     w_exp_or;
  logic             w_exp_lor;
  logic [VW-1:0]    w_exp_not;
  logic             w_mismatch;

  assign w_exp_or   = r_vec[VW-1:W] | r_vec[W-1:0];
  assign w_exp_lor  = |r_vec;
  assign w_exp_not  = ~r_vec;
  assign w_mismatch = (bus.or_bitwise_in != w_exp_or) || (bus.or_logical_in != w_exp_lor) ||
                      (bus.not_in != w_exp_not);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_vec    <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else begin
      r_state  <= w_state_d;
      r_vec    <= w_vec_d;
      r_cnt    <= w_cnt_d;
      r_err    <= w_err_d;
      r_ff_vld <= w_ff_vld_d;
      r_ff_vec <= w_ff_vec_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_vec_d    = r_vec;
    w_cnt_d    = r_cnt;
    w_err_d    = r_err;
    w_ff_vld_d = r_ff_vld;
    w_ff_vec_d = r_ff_vec;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_state_d  = StDrive;
          w_vec_d    = '0;
          w_err_d    = '0;
          w_ff_vld_d = 1'b0;
          w_ff_vec_d = '0;
        end
      end
      StDrive: begin
        w_cnt_d   = '0;
        w_state_d = (SETTLE == 0) ? StCheck : StWait;
      end
      StWait: begin
        if (r_cnt == SettleLast) w_state_d = StCheck;
        else                     w_cnt_d   = r_cnt + 1'b1;
      end
      StCheck: begin
        // One count per failing vector; only the earliest failure is latched.
        if (w_mismatch) begin
          if (r_err != ErrMax) w_err_d = r_err + 1'b1;
          if (!r_ff_vld) begin
            w_ff_vld_d = 1'b1;
            w_ff_vec_d = r_vec;
          end
        end
        if (r_vec == VecLast) begin
          w_state_d = StDone;
        end else begin
          w_vec_d   = r_vec + 1'b1;
          w_state_d = StDrive;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // r_vec only moves on entry to DRIVE, so the operands come straight from it.
  assign bus.a_out          = r_vec[VW-1:W];
  assign bus.b_out          = r_vec[W-1:0];
  assign bus.busy           = (r_state == StDrive) || (r_state == StWait) ||
                              (r_state == StCheck);
  assign bus.done           = (r_state == StDone);
  assign bus.pass           = (r_state == StDone) && (r_err == '0);
  assign bus.err_count      = r_err;
  assign bus.first_fail_vld = r_ff_vld;
  assign bus.first_fail_vec = r_ff_vec;
endmodule

// File: tb/tb_bitwise_selfcheck.sv
// Bench: two engines (SETTLE=1/ERR_W=8 and SETTLE=0/ERR_W=4) against a modelled bitwise block
// whose responses are corrupted per vector from a fault table.
module tb_bitwise_selfcheck;
  logic clk = 1'b0;
  logic rst;
  logic start;
  int   n_checks = 0;
  int   n_errors = 0;

  // Per-vector corruption: [9:7] or_bitwise, [6] or_logical, [5:0] not.
  logic [9:0] flip [64];
  logic [5:0] v0, v1;

  always #5 clk = ~clk;

  bitwise_selfcheck_if #(.W(3), .ERR_W(8)) bus0 ();
  bitwise_selfcheck_if #(.W(3), .ERR_W(4)) bus1 ();

  bitwise_selfcheck #(.W(3), .SETTLE(1), .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bitwise_selfcheck #(.W(3), .SETTLE(0), .ERR_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start = start;
  assign bus1.start = start;
  assign v0 = {bus0.a_out, bus0.b_out};
  assign v1 = {bus1.a_out, bus1.b_out};

  always_comb begin
    bus0.or_bitwise_in = (bus0.a_out | bus0.b_out) ^ flip[v0][9:7];
    bus0.or_logical_in = ((bus0.a_out != 3'd0) || (bus0.b_out != 3'd0)) ^ flip[v0][6];
    bus0.not_in        = (~v0) ^ flip[v0][5:0];
    bus1.or_bitwise_in = (bus1.a_out | bus1.b_out) ^ flip[v1][9:7];
    bus1.or_logical_in = ((bus1.a_out != 3'd0) || (bus1.b_out != 3'd0)) ^ flip[v1][6];
    bus1.not_in        = (~v1) ^ flip[v1][5:0];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // 0 clean, 1 or_logical stuck at 0, 2 not_in[0] inverted, 3 random sparse faults
  task automatic set_flips(input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        1:       flip[i] = (i != 0) ? 10'h040 : 10'h000;
        2:       flip[i] = 10'h001;
        3:       flip[i] = ($urandom_range(7) == 0) ? 10'($urandom_range(1, 1023)) : 10'h000;
        default: flip[i] = 10'h000;
      endcase
    end
  endtask

  function automatic void model(input int errmax, output int err, output int vld, output int fv);
    err = 0; vld = 0; fv = 0;
    for (int i = 0; i < 64; i++) begin
      if (flip[i] != 10'h000) begin
        if (err < errmax) err++;
        if (vld == 0) begin
          vld = 1;
          fv  = i;
        end
      end
    end
  endfunction

  task automatic sweep(input int extra, output int c0, output int c1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_err", 32'(bus0.err_count), 0);
    check("start_clears_vld", 32'(bus0.first_fail_vld), 0);
    check("start_busy", 32'(bus0.busy), 1);
    check("start_not_done", 32'(bus0.done), 0);
    check("start_vec0", 32'(v0), 0);
    c0 = -1;
    c1 = -1;
    for (int n = 1; n <= 1000 && (c0 < 0 || c1 < 0); n++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (c0 < 0 && bus0.done) c0 = n;
      if (c1 < 0 && bus1.done) c1 = n;
      if (extra > 0 && (n == 10 || n == 51 || n == 100)) start = 1'b1;
      if (n == 60) check("mid_busy", 32'(bus0.busy), 1);
    end
  endtask

  task automatic results(input string tag);
    int e, vld, fv;
    repeat (4) @(posedge clk);
    #1;
    model(255, e, vld, fv);
    check({tag, "_err0"}, 32'(bus0.err_count), 32'(e));
    check({tag, "_vld0"}, 32'(bus0.first_fail_vld), 32'(vld));
    check({tag, "_vec0"}, 32'(bus0.first_fail_vec), 32'(fv));
    check({tag, "_pass0"}, 32'(bus0.pass), (e == 0) ? 32'd1 : 32'd0);
    check({tag, "_done0"}, 32'(bus0.done), 1);
    check({tag, "_hold0"}, 32'(v0), 63);
    model(15, e, vld, fv);
    check({tag, "_err1"}, 32'(bus1.err_count), 32'(e));
    check({tag, "_vld1"}, 32'(bus1.first_fail_vld), 32'(vld));
    check({tag, "_vec1"}, 32'(bus1.first_fail_vec), 32'(fv));
    check({tag, "_pass1"}, 32'(bus1.pass), (e == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic run(input string tag, input int mode, input int extra);
    int c0, c1;
    set_flips(mode);
    sweep(extra, c0, c1);
    check({tag, "_cyc0"}, 32'(c0), 192);
    check({tag, "_cyc1"}, 32'(c1), 128);
    results(tag);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 32'(bus0.a_out), 0);
    check({tag, "_b"}, 32'(bus0.b_out), 0);
    check({tag, "_busy"}, 32'(bus0.busy), 0);
    check({tag, "_done"}, 32'(bus0.done), 0);
    check({tag, "_pass"}, 32'(bus0.pass), 0);
    check({tag, "_err"}, 32'(bus0.err_count), 0);
    check({tag, "_vld"}, 32'(bus0.first_fail_vld), 0);
    check({tag, "_fvec"}, 32'(bus0.first_fail_vec), 0);
  endtask

  initial begin
    int found;
    rst   = 1'b1;
    start = 1'b0;
    set_flips(0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", 32'(bus0.busy), 0);

    run("clean", 0, 1);
    run("lor0", 1, 0);
    run("not0", 2, 1);
    for (int k = 0; k < 4; k++) run($sformatf("rnd%0d", k), 3, k % 2);

    // Abort mid-sweep: reach vector 20, step into its settle cycle, then reset.
    set_flips(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 500 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (v0 == 6'd20) found = 1;
    end
    check("rst_reach_vec20", 32'(found), 1);
    @(posedge clk);
    #1;
    check("pre_rst_err", 32'(bus0.err_count), 20);
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst_after");

    run("after_rst", 0, 0);
    run("rerun", 3, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
